// File: rtl/uart_host_loader.sv
// ============================================================================
// Module      : uart_host_loader
// Description : Host-side UART boot loader. Waits for the CPU ready byte
//               (0xAA), sends a 4-byte big-endian length and the program
//               bytes from a synchronous ROM, then captures every byte the
//               CPU emits into a FIFO.
//               Optional macro UART_HOST_LOADER_CHECKSUM_EN appends an XOR
//               checksum byte after the program.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_host_loader #(
    parameter int PROG_AW = 15,
    parameter int CAP_AW  = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rdata,
    input  logic               rx_ready,
    output logic [7:0]         odata,
    output logic               tx_start,
    input  logic               tx_busy,
    input  logic [PROG_AW:0]   prog_len,
    output logic [PROG_AW-1:0] rom_addr,
    input  logic [7:0]         rom_data,
    input  logic               cap_rd,
    output logic [7:0]         cap_data,
    output logic               cap_empty,
    output logic               cap_ovf,
    output logic               loaded
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PROG    = 3'd2,
        ST_CSUM    = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        PH_SETUP = 3'd0,
        PH_FETCH = 3'd1,
        PH_START = 3'd2,
        PH_GAP   = 3'd3,
        PH_WAIT  = 3'd4
    } phase_t;

`ifdef UART_HOST_LOADER_CHECKSUM_EN
    localparam state_t c_AFTER_PROG = ST_CSUM;
`else
    localparam state_t c_AFTER_PROG = ST_CAPTURE;
`endif

    localparam int                c_DEPTH   = 1 << CAP_AW;
    localparam logic [PROG_AW:0]  c_CNT_ONE = {{PROG_AW{1'b0}}, 1'b1};
    localparam logic [CAP_AW:0]   c_PTR_ONE = {{CAP_AW{1'b0}}, 1'b1};
    localparam logic [CAP_AW:0]   c_PTR_MSB = {1'b1, {CAP_AW{1'b0}}};

    state_t             r_state;
    phase_t             r_phase;
    logic [PROG_AW:0]   r_len;
    logic [PROG_AW:0]   r_cnt;
    logic [PROG_AW:0]   w_cnt_inc;
    logic [31:0]        w_len32;
    logic [7:0]         w_len_byte;
`ifdef UART_HOST_LOADER_CHECKSUM_EN
    logic [7:0]         r_csum;
`endif

    assign w_cnt_inc = r_cnt + c_CNT_ONE;
    assign w_len32   = {{(31 - PROG_AW){1'b0}}, r_len};

    always_comb begin
        w_len_byte = 8'h00;
        case (r_cnt[1:0])
            2'd0:    w_len_byte = w_len32[31:24];
            2'd1:    w_len_byte = w_len32[23:16];
            2'd2:    w_len_byte = w_len32[15:8];
            default: w_len_byte = w_len32[7:0];
        endcase
    end

    // Main load sequencer: outer state selects the byte source, r_phase
    // steps each byte through setup/fetch/start/gap/wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_phase  <= PH_FETCH;
            r_len    <= '0;
            r_cnt    <= '0;
            odata    <= 8'h00;
            tx_start <= 1'b0;
            rom_addr <= '0;
            loaded   <= 1'b0;
`ifdef UART_HOST_LOADER_CHECKSUM_EN
            r_csum   <= 8'h00;
`endif
        end else begin
            tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_ready && (rdata == 8'hAA)) begin
                        r_len   <= prog_len;
                        r_cnt   <= '0;
                        r_state <= ST_LEN;
                        r_phase <= PH_FETCH;
`ifdef UART_HOST_LOADER_CHECKSUM_EN
                        r_csum  <= 8'h00;
`endif
                    end
                end
                ST_LEN, ST_PROG, ST_CSUM: begin
                    case (r_phase)
                        PH_SETUP: r_phase <= PH_FETCH;
                        PH_FETCH: begin
                            if (r_state == ST_LEN) begin
                                odata <= w_len_byte;
                            end else if (r_state == ST_PROG) begin
                                odata  <= rom_data;
`ifdef UART_HOST_LOADER_CHECKSUM_EN
                                r_csum <= r_csum ^ rom_data;
                            end else begin
                                odata  <= r_csum;
`endif
                            end
                            r_phase <= PH_START;
                        end
                        PH_START: begin
                            tx_start <= 1'b1;
                            r_phase  <= PH_GAP;
                        end
                        PH_GAP: r_phase <= PH_WAIT;
                        PH_WAIT: begin
                            if (!tx_busy) begin
                                if (r_state == ST_LEN) begin
                                    if (r_cnt[1:0] == 2'd3) begin
                                        r_cnt <= '0;
                                        if (r_len == '0) begin
                                            r_state <= c_AFTER_PROG;
                                            r_phase <= PH_FETCH;
                                            loaded  <= (c_AFTER_PROG == ST_CAPTURE);
                                        end else begin
                                            r_state  <= ST_PROG;
                                            r_phase  <= PH_SETUP;
                                            rom_addr <= '0;
                                        end
                                    end else begin
                                        r_cnt   <= w_cnt_inc;
                                        r_phase <= PH_FETCH;
                                    end
                                end else if (r_state == ST_PROG) begin
                                    if (w_cnt_inc == r_len) begin
                                        r_state <= c_AFTER_PROG;
                                        r_phase <= PH_FETCH;
                                        loaded  <= (c_AFTER_PROG == ST_CAPTURE);
                                    end else begin
                                        r_cnt    <= w_cnt_inc;
                                        rom_addr <= w_cnt_inc[PROG_AW-1:0];
                                        r_phase  <= PH_SETUP;
                                    end
                                end else begin
                                    r_state <= ST_CAPTURE;
                                    loaded  <= 1'b1;
                                end
                            end
                        end
                        default: r_phase <= PH_FETCH;
                    endcase
                end
                ST_CAPTURE: r_state <= ST_CAPTURE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    // Capture FIFO: extra pointer MSB distinguishes full from empty.
    logic [7:0]       r_mem [c_DEPTH];
    logic [CAP_AW:0]  r_wr_ptr;
    logic [CAP_AW:0]  r_rd_ptr;
    logic             w_full;
    logic             w_push_req;
    logic             w_push;
    logic             w_pop;

    assign cap_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full     = ((r_wr_ptr ^ r_rd_ptr) == c_PTR_MSB);
    assign w_push_req = rx_ready && (r_state == ST_CAPTURE);
    assign w_pop      = cap_rd && !cap_empty;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign cap_data   = r_mem[r_rd_ptr[CAP_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            cap_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push_req && w_full && !w_pop) begin
                cap_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[CAP_AW-1:0]] <= rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_host_loader.sv
// ============================================================================
// Module      : tb_uart_host_loader
// Description : Directed bench for uart_host_loader with a uart_tx model and
//               a transmit scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_host_loader;

    localparam int PAW = 4;
    localparam int CAW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     rdata = 8'h00;
    logic           rx_ready = 1'b0;
    logic [7:0]     odata;
    logic           tx_start;
    logic           tx_busy = 1'b0;
    logic [PAW:0]   prog_len = '0;
    logic [PAW-1:0] rom_addr;
    logic [7:0]     rom_data = 8'h00;
    logic           cap_rd = 1'b0;
    logic [7:0]     cap_data;
    logic           cap_empty;
    logic           cap_ovf;
    logic           loaded;

    always #5 clk = ~clk;

    uart_host_loader #(.PROG_AW(PAW), .CAP_AW(CAW)) dut (
        .clk(clk), .rst(rst), .rdata(rdata), .rx_ready(rx_ready),
        .odata(odata), .tx_start(tx_start), .tx_busy(tx_busy),
        .prog_len(prog_len), .rom_addr(rom_addr), .rom_data(rom_data),
        .cap_rd(cap_rd), .cap_data(cap_data), .cap_empty(cap_empty),
        .cap_ovf(cap_ovf), .loaded(loaded)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] rom [16];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // uart_tx model: busy rises the cycle after tx_start, held busy_len cycles
    int         busy_len = 2;
    int         busy_cnt = 0;
    logic [7:0] tx_latched = 8'h00;
    always @(posedge clk) begin
        if (tx_start) begin
            tx_busy    <= 1'b1;
            busy_cnt   <= busy_len;
            tx_latched <= odata;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt <= 0;
            tx_busy  <= 1'b0;
        end
    end

    logic [7:0] exp_tx [$];
    int         n_tx = 0;
    bit         prev_busy = 1'b0;
    bit         lat_ok = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            lat_ok = 1'b0;
        end else begin
            if (tx_start) begin
                n_tx++;
                chk("tx_expected", {31'd0, exp_tx.size() != 0}, 32'd1);
                if (exp_tx.size() != 0) chk("tx_byte", {24'd0, odata}, {24'd0, exp_tx.pop_front()});
                lat_ok = 1'b1;
            end
            if (prev_busy && !tx_busy && lat_ok) begin
                chk("odata_hold", {24'd0, odata}, {24'd0, tx_latched});
                lat_ok = 1'b0;
            end
        end
        prev_busy = tx_busy;
    end

    task automatic send_rx(input logic [7:0] b);
        rdata    = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        rdata    = 8'h00;
    endtask

    task automatic pop();
        cap_rd = 1'b1;
        @(negedge clk);
        cap_rd = 1'b0;
    endtask

    task automatic push_hdr(input int len, input int n);
        logic [31:0] l32;
        logic [7:0]  cs;
        l32 = len;
        cs  = 8'h00;
        exp_tx.push_back(l32[31:24]);
        exp_tx.push_back(l32[23:16]);
        exp_tx.push_back(l32[15:8]);
        exp_tx.push_back(l32[7:0]);
        for (int i = 0; i < n; i++) begin
            exp_tx.push_back(rom[i]);
            cs = cs ^ rom[i];
        end
`ifdef UART_HOST_LOADER_CHECKSUM_EN
        exp_tx.push_back(cs);
`endif
    endtask

    task automatic wait_loaded(input int budget);
        int i;
        i = 0;
        while (!loaded && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("loaded", {31'd0, loaded}, 32'd1);
    endtask

    task automatic wait_tx_idle();
        int i;
        i = 0;
        while (tx_busy && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("tx_idle", {31'd0, tx_busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int snap;
        int i;
        for (int k = 0; k < 16; k++) rom[k] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_odata", {24'd0, odata}, 32'd0);
        chk("rst_rom_addr", {28'd0, rom_addr}, 32'd0);
        chk("rst_loaded", {31'd0, loaded}, 32'd0);
        chk("rst_cap_ovf", {31'd0, cap_ovf}, 32'd0);
        chk("rst_cap_empty", {31'd0, cap_empty}, 32'd1);
        rst = 1'b0;

        // Basic load: 0x55 ignored, then 3-byte program
        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33;
        prog_len = 5'd3;
        send_rx(8'h55);
        repeat (5) @(negedge clk);
        chk("ignore_55_tx", n_tx, 32'd0);
        chk("ignore_55_cap", {31'd0, cap_empty}, 32'd1);
        push_hdr(3, 3);
        send_rx(8'hAA);
        wait_loaded(500);
        chk("sb_drained_1", exp_tx.size(), 32'd0);
        chk("cap_empty_after_load", {31'd0, cap_empty}, 32'd1);

        // 0xAA in CAPTURE is data
        wait_tx_idle();
        snap = n_tx;
        send_rx(8'hAA);
        send_rx(8'h07);
        repeat (20) @(negedge clk);
        chk("no_restart", n_tx, snap);
        chk("cap_aa", {24'd0, cap_data}, 32'h0000_00AA);
        pop();
        chk("cap_07", {24'd0, cap_data}, 32'h0000_0007);
        pop();
        chk("cap_drained", {31'd0, cap_empty}, 32'd1);

        // Overflow with a 4-deep FIFO
        for (int k = 1; k <= 4; k++) send_rx(k[7:0]);
        chk("full_no_ovf", {31'd0, cap_ovf}, 32'd0);
        send_rx(8'h05);
        chk("ovf_set", {31'd0, cap_ovf}, 32'd1);
        rdata = 8'h06; rx_ready = 1'b1; cap_rd = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0; cap_rd = 1'b0;
        chk("ovf_sticky", {31'd0, cap_ovf}, 32'd1);
        chk("ff_head2", {24'd0, cap_data}, 32'h02); pop();
        chk("ff_head3", {24'd0, cap_data}, 32'h03); pop();
        chk("ff_head4", {24'd0, cap_data}, 32'h04); pop();
        chk("ff_head6", {24'd0, cap_data}, 32'h06); pop();
        chk("ff_empty", {31'd0, cap_empty}, 32'd1);
        pop();
        chk("pop_empty_ignored", {31'd0, cap_empty}, 32'd1);
        rdata = 8'h77; rx_ready = 1'b1; cap_rd = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0; cap_rd = 1'b0;
        chk("push_pop_empty", {24'd0, cap_data}, 32'h77);
        chk("push_pop_empty_ne", {31'd0, cap_empty}, 32'd0);

        // Zero-length program
        do_reset();
        chk("ovf_cleared", {31'd0, cap_ovf}, 32'd0);
        chk("empty_after_rst", {31'd0, cap_empty}, 32'd1);
        prog_len = 5'd0;
        push_hdr(0, 0);
        send_rx(8'hAA);
        wait_loaded(500);
        chk("sb_drained_0", exp_tx.size(), 32'd0);
        send_rx(8'h41);
        chk("cap_41", {24'd0, cap_data}, 32'h41);
        chk("cap_41_ne", {31'd0, cap_empty}, 32'd0);

        // Slow uart_tx, rx dropped during load
        wait_tx_idle();
        do_reset();
        busy_len = 50;
        rom[0] = 8'hA5; rom[1] = 8'h5A; rom[2] = 8'hC3;
        prog_len = 5'd3;
        push_hdr(3, 3);
        send_rx(8'hAA);
        repeat (100) @(negedge clk);
        send_rx(8'h99);
        wait_loaded(3000);
        chk("sb_drained_slow", exp_tx.size(), 32'd0);
        chk("rx_dropped_in_load", {31'd0, cap_empty}, 32'd1);
        chk("no_ovf_in_load", {31'd0, cap_ovf}, 32'd0);
        busy_len = 2;
        wait_tx_idle();

        // Reset mid-PROG after the second program byte
        do_reset();
        for (int k = 0; k < 5; k++) rom[k] = 8'hB1 + k[7:0];
        prog_len = 5'd5;
        snap = n_tx;
        exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h00); exp_tx.push_back(8'h05);
        exp_tx.push_back(rom[0]); exp_tx.push_back(rom[1]);
        send_rx(8'hAA);
        i = 0;
        while (n_tx < snap + 6 && i < 500) begin
            @(negedge clk);
            i++;
        end
        chk("reached_prog_byte2", n_tx, snap + 6);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rom_addr", {28'd0, rom_addr}, 32'd0);
        chk("abort_loaded", {31'd0, loaded}, 32'd0);
        chk("abort_sb", exp_tx.size(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_tx_idle();
        prog_len = 5'd2;
        push_hdr(2, 2);
        send_rx(8'hAA);
        repeat (10) @(negedge clk);
        chk("restart_not_loaded", {31'd0, loaded}, 32'd0);
        wait_loaded(500);
        chk("sb_drained_restart", exp_tx.size(), 32'd0);

        repeat (10) @(negedge clk);
        chk("sb_final", exp_tx.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
